// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, memory size and
// the memory-stage controller state encoding.
package y86_pkg;

    // Instruction codes (icode field)
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Status codes
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    // Default data memory size in bytes
    localparam int MEM_BYTES_DEF = 65536;

    // Memory-stage controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_RESP    = 2'd3
    } mem_state_t;

    // True for instructions that touch data memory
    function automatic logic is_mem_icode(input logic [3:0] icode);
        logic r;
        case (icode)
            IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: r = 1'b1;
            default:                                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_addr_check.sv
// Bounds check for an 8-byte data memory access. The comparison is made
// against the last legal base address so that no addr+7 sum can wrap.
module dmem_addr_check #(
    parameter int N         = 64,
    parameter int MEM_BYTES = 65536
) (
    input  logic [N-1:0] addr,
    output logic         in_bounds
);

    localparam logic [N-1:0] LAST_LEGAL = N'(MEM_BYTES) - N'(32'd8);

    // Any address above the last legal base (upper bits included) is rejected
    always_comb begin
        in_bounds = (addr <= LAST_LEGAL);
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage initiator for the Y86-64 core. Takes one operation from execute,
// issues a single-cycle access to the data memory (or flags an address error),
// and returns valM/stat to writeback on a valid/ready handshake.
module dmem_access_ctrl
    import y86_pkg::*;
#(
    parameter int N         = 64,
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_icode,
    input  logic [N-1:0] req_valE,
    input  logic [N-1:0] req_valA,
    input  logic [N-1:0] req_valP,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         mem_ren,
    output logic         mem_wen,
    output logic         mem_err,
    input  logic [N-1:0] mem_rdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_valM,
    output logic [2:0]   resp_stat
);

    mem_state_t   state_r;
    mem_state_t   state_s;

    logic [3:0]   icode_r;
    logic [N-1:0] vale_r;
    logic [N-1:0] vala_r;
    logic [N-1:0] valp_r;

    logic         resp_valid_r;
    logic [N-1:0] resp_valm_r;
    logic [2:0]   resp_stat_r;

    logic [N-1:0] addr_s;
    logic [N-1:0] wdata_s;
    logic         rd_op_s;
    logic         wr_op_s;
    logic         in_bounds_s;

    dmem_addr_check #(
        .N         (N),
        .MEM_BYTES (MEM_BYTES)
    ) u_addr_check (
        .addr      (addr_s),
        .in_bounds (in_bounds_s)
    );

    // Decode the latched request into address, write data and access direction
    always_comb begin
        addr_s  = {N{1'b0}};
        wdata_s = {N{1'b0}};
        rd_op_s = 1'b0;
        wr_op_s = 1'b0;
        case (icode_r)
            IRMMOVQ, IPUSHQ: begin
                addr_s  = vale_r;
                wdata_s = vala_r;
                wr_op_s = 1'b1;
            end
            ICALL: begin
                addr_s  = vale_r;
                wdata_s = valp_r;
                wr_op_s = 1'b1;
            end
            IMRMOVQ: begin
                addr_s  = vale_r;
                rd_op_s = 1'b1;
            end
            IRET, IPOPQ: begin
                addr_s  = vala_r;
                rd_op_s = 1'b1;
            end
            default: begin
                addr_s  = {N{1'b0}};
                wdata_s = {N{1'b0}};
                rd_op_s = 1'b0;
                wr_op_s = 1'b0;
            end
        endcase
    end

    // Memory-side strobes: only in ISSUE, and never while reset is high
    always_comb begin
        mem_addr  = {N{1'b0}};
        mem_wdata = {N{1'b0}};
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_err   = 1'b0;
        if (!reset && (state_r == ST_ISSUE)) begin
            mem_addr  = addr_s;
            mem_wdata = wdata_s;
            if (in_bounds_s) begin
                mem_ren = rd_op_s;
                mem_wen = wr_op_s & ~rd_op_s;
            end else begin
                mem_err = 1'b1;
            end
        end else begin
            mem_addr  = {N{1'b0}};
            mem_wdata = {N{1'b0}};
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (is_mem_icode(req_icode)) begin
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_RESP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!in_bounds_s) begin
                    state_s = ST_RESP;
                end else if (rd_op_s) begin
                    state_s = ST_WAIT_RD;
                end else begin
                    state_s = ST_RESP;
                end
            end
            ST_WAIT_RD: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (resp_valid_r && resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture the request on acceptance; held until the next acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            icode_r <= 4'h0;
            vale_r  <= {N{1'b0}};
            vala_r  <= {N{1'b0}};
            valp_r  <= {N{1'b0}};
        end else if ((state_r == ST_IDLE) && req_valid) begin
            icode_r <= req_icode;
            vale_r  <= req_valE;
            vala_r  <= req_valA;
            valp_r  <= req_valP;
        end else begin
            icode_r <= icode_r;
            vale_r  <= vale_r;
            vala_r  <= vala_r;
            valp_r  <= valp_r;
        end
    end

    // Response registers: result loaded along the way, valid raised one cycle
    // after entering RESP and dropped on the handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_r <= 1'b0;
            resp_valm_r  <= {N{1'b0}};
            resp_stat_r  <= SAOK;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_valid_r <= 1'b0;
                    if (req_valid) begin
                        resp_valm_r <= {N{1'b0}};
                        resp_stat_r <= SAOK;
                    end else begin
                        resp_valm_r <= resp_valm_r;
                        resp_stat_r <= resp_stat_r;
                    end
                end
                ST_ISSUE: begin
                    resp_valid_r <= 1'b0;
                    resp_valm_r  <= {N{1'b0}};
                    if (in_bounds_s) begin
                        resp_stat_r <= SAOK;
                    end else begin
                        resp_stat_r <= SADR;
                    end
                end
                ST_WAIT_RD: begin
                    resp_valid_r <= 1'b0;
                    resp_valm_r  <= mem_rdata;
                    resp_stat_r  <= SAOK;
                end
                ST_RESP: begin
                    resp_valm_r <= resp_valm_r;
                    resp_stat_r <= resp_stat_r;
                    if (!resp_valid_r) begin
                        resp_valid_r <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                    end else begin
                        resp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    resp_valm_r  <= resp_valm_r;
                    resp_stat_r  <= resp_stat_r;
                end
            endcase
        end
    end

    assign req_ready  = (state_r == ST_IDLE) && !reset;
    assign resp_valid = resp_valid_r;
    assign resp_valM  = resp_valm_r;
    assign resp_stat  = resp_stat_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a little-endian byte memory model.
module tb_dmem_access_ctrl;
    import y86_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_icode;
    logic [63:0] req_valE;
    logic [63:0] req_valA;
    logic [63:0] req_valP;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ren;
    logic        mem_wen;
    logic        mem_err;
    logic [63:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_valM;
    logic [2:0]  resp_stat;

    int tests = 0;
    int fails = 0;
    int en_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    bit   [7:0]  mem [0:65535];
    logic [63:0] rdata_q = 64'h0;

    dmem_access_ctrl #(.N(64), .MEM_BYTES(65536)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_icode  (req_icode),
        .req_valE   (req_valE),
        .req_valA   (req_valA),
        .req_valP   (req_valP),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_err    (mem_err),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_valM  (resp_valM),
        .resp_stat  (resp_stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit legal(input logic [63:0] a);
        return (a[63:16] == 48'h0) && (a[15:0] <= 16'hFFF8);
    endfunction

    function automatic logic [63:0] rd8(input logic [63:0] a);
        logic [63:0] r;
        r = 64'h0;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mem[int'(a[15:0]) + i];
        return r;
    endfunction

    // Data memory model: rdata valid the cycle after ren, zeroed on error
    always @(posedge clk) begin
        if (mem_err) rdata_q <= 64'h0;
        else if (mem_ren && legal(mem_addr)) rdata_q <= rd8(mem_addr);
        if (mem_wen && !mem_err && legal(mem_addr))
            for (int i = 0; i < 8; i++) mem[int'(mem_addr[15:0]) + i] <= mem_wdata[8*i +: 8];
    end
    assign mem_rdata = rdata_q;

    // Count strobe cycles away from the active edge
    always @(negedge clk) begin
        if (mem_ren || mem_wen) en_cnt <= en_cnt + 1;
        if (mem_err) err_cnt <= err_cnt + 1;
        if (mem_ren && mem_wen) both_cnt <= both_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [3:0]  icode;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [63:0] valp;
        logic        exp_ren;
        logic        exp_wen;
        logic        exp_err;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [63:0] exp_valm;
        logic [2:0]  exp_stat;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [3:0] ic, input logic [63:0] e,
                                input logic [63:0] a, input logic [63:0] p,
                                input logic r, input logic w, input logic er,
                                input logic [63:0] ad, input logic [63:0] wd,
                                input logic [63:0] vm, input logic [2:0] st, input int lat);
        vec_t v;
        v.name = nm; v.icode = ic; v.vale = e; v.vala = a; v.valp = p;
        v.exp_ren = r; v.exp_wen = w; v.exp_err = er; v.exp_addr = ad; v.exp_wdata = wd;
        v.exp_valm = vm; v.exp_stat = st; v.exp_lat = lat;
        return v;
    endfunction

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, ".ready"}, {63'h0, req_ready}, 64'h1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int en0;
        int err0;
        bit got;
        wait_ready(v.name);
        req_icode = v.icode; req_valE = v.vale; req_valA = v.vala; req_valP = v.valp;
        req_valid = 1'b1;
        en0 = en_cnt; err0 = err_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({v.name, ".ren"}, {63'h0, mem_ren}, {63'h0, v.exp_ren});
        chk({v.name, ".wen"}, {63'h0, mem_wen}, {63'h0, v.exp_wen});
        chk({v.name, ".err"}, {63'h0, mem_err}, {63'h0, v.exp_err});
        if (v.exp_ren || v.exp_wen || v.exp_err) chk({v.name, ".addr"}, mem_addr, v.exp_addr);
        if (v.exp_wen) chk({v.name, ".wdata"}, mem_wdata, v.exp_wdata);
        lat = 0; got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk); #1;
            lat++;
            if (resp_valid) got = 1'b1;
        end
        chk({v.name, ".resp_seen"}, {63'h0, got}, 64'h1);
        chk({v.name, ".latency"}, 64'(lat), 64'(v.exp_lat));
        chk({v.name, ".valM"}, resp_valM, v.exp_valm);
        chk({v.name, ".stat"}, {61'h0, resp_stat}, {61'h0, v.exp_stat});
        @(posedge clk); #1;
        chk({v.name, ".valid_drop"}, {63'h0, resp_valid}, 64'h0);
        chk({v.name, ".en_cycles"}, 64'(en_cnt - en0), (v.exp_ren || v.exp_wen) ? 64'h1 : 64'h0);
        chk({v.name, ".err_cycles"}, 64'(err_cnt - err0), {63'h0, v.exp_err});
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = mk("rmmovq",   IRMMOVQ, 64'h100, 64'h1122334455667788, 64'h0, 1'b0, 1'b1, 1'b0,
                      64'h100, 64'h1122334455667788, 64'h0, SAOK, 2);
        vecs[1]  = mk("mrmovq",   IMRMOVQ, 64'h100, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0,
                      64'h100, 64'h0, 64'h1122334455667788, SAOK, 3);
        vecs[2]  = mk("call",     ICALL, 64'hFFF8, 64'h0, 64'h2A, 1'b0, 1'b1, 1'b0,
                      64'hFFF8, 64'h2A, 64'h0, SAOK, 2);
        vecs[3]  = mk("ret",      IRET, 64'h0, 64'hFFF8, 64'h0, 1'b1, 1'b0, 1'b0,
                      64'hFFF8, 64'h0, 64'h2A, SAOK, 3);
        vecs[4]  = mk("push_oob", IPUSHQ, 64'hFFF9, 64'h55, 64'h0, 1'b0, 1'b0, 1'b1,
                      64'hFFF9, 64'h0, 64'h0, SADR, 2);
        vecs[5]  = mk("pop_max",  IPOPQ, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0, 1'b0, 1'b1,
                      64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, SADR, 2);
        vecs[6]  = mk("opq",      IOPQ, 64'h1234, 64'h5678, 64'h9, 1'b0, 1'b0, 1'b0,
                      64'h0, 64'h0, 64'h0, SAOK, 1);
        vecs[7]  = mk("push0",    IPUSHQ, 64'h0, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0, 1'b1, 1'b0,
                      64'h0, 64'hDEADBEEFCAFEF00D, 64'h0, SAOK, 2);
        vecs[8]  = mk("pop0",     IPOPQ, 64'h40, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0,
                      64'h0, 64'h0, 64'hDEADBEEFCAFEF00D, SAOK, 3);
        vecs[9]  = mk("mr_last",  IMRMOVQ, 64'hFFF8, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0,
                      64'hFFF8, 64'h0, 64'h2A, SAOK, 3);
        vecs[10] = mk("irmovq",   IIRMOVQ, 64'h77, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0,
                      64'h0, 64'h0, 64'h0, SAOK, 1);
        vecs[11] = mk("mr_10000", IMRMOVQ, 64'h10000, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1,
                      64'h10000, 64'h0, 64'h0, SADR, 2);
        vecs[12] = mk("rm_upper", IRMMOVQ, 64'h0000000100000100, 64'h99, 64'h0, 1'b0, 1'b0, 1'b1,
                      64'h0000000100000100, 64'h0, 64'h0, SADR, 2);

        reset = 1'b1; req_valid = 1'b0; req_icode = 4'h0;
        req_valE = 64'h0; req_valA = 64'h0; req_valP = 64'h0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ren", {63'h0, mem_ren}, 64'h0);
        chk("rst.wen", {63'h0, mem_wen}, 64'h0);
        chk("rst.err", {63'h0, mem_err}, 64'h0);
        chk("rst.resp_valid", {63'h0, resp_valid}, 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst.req_ready", {63'h0, req_ready}, 64'h1);
        chk("rst.resp_valM", resp_valM, 64'h0);
        chk("rst.resp_stat", {61'h0, resp_stat}, {61'h0, SAOK});

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Backpressure on a read: response must hold and nothing new may issue
        begin
            bit got;
            wait_ready("bp");
            resp_ready = 1'b0;
            req_icode = IMRMOVQ; req_valE = 64'h100; req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(posedge clk); #1;
                if (resp_valid) got = 1'b1;
            end
            chk("bp.resp_seen", {63'h0, got}, 64'h1);
            req_icode = IRMMOVQ; req_valE = 64'h300; req_valA = 64'hA5A5A5A5A5A5A5A5;
            req_valid = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                chk("bp.valid", {63'h0, resp_valid}, 64'h1);
                chk("bp.valM", resp_valM, 64'h1122334455667788);
                chk("bp.req_ready", {63'h0, req_ready}, 64'h0);
                chk("bp.enables", {62'h0, mem_ren, mem_wen}, 64'h0);
            end
            req_valid = 1'b0;
            resp_ready = 1'b1;
            @(posedge clk); #1;
            chk("bp.release_valid", {63'h0, resp_valid}, 64'h0);
            chk("bp.release_ready", {63'h0, req_ready}, 64'h1);
            chk("bp.no_write", rd8(64'h300), 64'h0);
        end

        // Reset asserted during the ISSUE cycle of a write
        begin
            wait_ready("rstmid");
            req_icode = IRMMOVQ; req_valE = 64'h200; req_valA = 64'hFEEDFACE01234567;
            req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            reset = 1'b1;
            #1;
            chk("rstmid.wen", {63'h0, mem_wen}, 64'h0);
            chk("rstmid.err", {63'h0, mem_err}, 64'h0);
            chk("rstmid.addr", mem_addr, 64'h0);
            @(posedge clk); #1;
            reset = 1'b0;
            #1;
            chk("rstmid.resp_valid", {63'h0, resp_valid}, 64'h0);
            chk("rstmid.req_ready", {63'h0, req_ready}, 64'h1);
            chk("rstmid.stat", {61'h0, resp_stat}, {61'h0, SAOK});
            chk("rstmid.mem", rd8(64'h200), 64'h0);
            repeat (2) @(posedge clk);
            #1;
            chk("rstmid.quiet", {63'h0, resp_valid | mem_wen | mem_ren}, 64'h0);
            chk("rstmid.mem_later", rd8(64'h200), 64'h0);
        end

        chk("ren_wen_overlap", 64'(both_cnt), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
